// File: rtl/score_pkg.sv
// score_pkg: shared state encoding, widths and score/level constants for the score path
package score_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_e;
  localparam int SCORE_W = 13;
  localparam int LEVEL_W = 3;
  localparam int SCORE_MAX_DEF = 6399;
  localparam int LEVEL_STEP_DEF = 800;
  function automatic logic [LEVEL_W-1:0] level_of(input logic [SCORE_W-1:0] s, input int step);
    int q;
    q = int'(s) / step;
    return (q > 7) ? LEVEL_W'(7) : LEVEL_W'(q);
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts enabled clk2 cycles modulo TICK_DIV; tick is high during the last count so the wrap edge consumes it
module tick_prescaler #(
  parameter int TICK_DIV = 5000000
) (
  input  logic clk2,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick_q, tick_d;
  always_comb begin
    cnt_d  = clr ? '0 : en ? ((cnt_q == LAST) ? '0 : cnt_q + 1'b1) : cnt_q;
    tick_d = clr ? 1'b0 : en ? (cnt_d == LAST) : tick_q;
  end
  always_ff @(posedge clk2 or negedge reset)
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  assign tick = tick_q;
endmodule

// File: rtl/score_counter.sv
// score_counter: per-game score FSM with tick/bonus accrual, saturation and difficulty level
// Optional best-score register and hiscore port enabled by SCORE_HISCORE_EN.
module score_counter import score_pkg::*; #(
  parameter int TICK_DIV   = 5000000,
  parameter int BONUS_PTS  = 10,
  parameter int SCORE_MAX  = SCORE_MAX_DEF,
  parameter int LEVEL_STEP = LEVEL_STEP_DEF
) (
  input  logic               clk2,
  input  logic               reset,
  input  logic               start,
  input  logic               collide,
  input  logic               bonus,
  input  logic               pause,
  output logic [SCORE_W-1:0] score,
  output logic [LEVEL_W-1:0] level,
  output logic               running,
`ifdef SCORE_HISCORE_EN
  output logic [SCORE_W-1:0] hiscore,
`endif
  output logic               game_over
);
  localparam logic [SCORE_W:0]   BONUS_X = (SCORE_W+1)'(BONUS_PTS);
  localparam logic [SCORE_W:0]   MAX_X   = (SCORE_W+1)'(SCORE_MAX);
  localparam logic [SCORE_W-1:0] MAX_S   = SCORE_W'(SCORE_MAX);
  state_e state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic running_q, game_over_q;
  logic in_run, go_run, go_over, accrue, tick;
  logic [SCORE_W:0] sum;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk2 (clk2),
    .reset(reset),
    .en   (in_run & ~pause),
    .clr  (go_run),
    .tick (tick)
  );
  // collide outranks any tick or bonus arriving on the same edge
  always_comb begin
    in_run  = (state_q == RUN);
    go_run  = start & ~in_run;
    go_over = in_run & collide;
    accrue  = in_run & ~pause & ~collide;
    sum     = {1'b0, score_q} + {{SCORE_W{1'b0}}, tick} + (bonus ? BONUS_X : '0);
    score_d = go_run ? '0 : accrue ? ((sum > MAX_X) ? MAX_S : sum[SCORE_W-1:0]) : score_q;
    state_d = go_run ? RUN : go_over ? OVER : state_q;
    level_d = level_of(score_d, LEVEL_STEP);
  end
  always_ff @(posedge clk2 or negedge reset)
    if (!reset) begin
      state_q     <= IDLE;
      score_q     <= '0;
      level_q     <= '0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      level_q     <= level_d;
      running_q   <= (state_d == RUN);
      game_over_q <= (state_d == OVER);
    end
`ifdef SCORE_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q, hiscore_d;
  always_comb hiscore_d = (go_over && score_q > hiscore_q) ? score_q : hiscore_q;
  always_ff @(posedge clk2 or negedge reset)
    if (!reset) hiscore_q <= '0;
    else hiscore_q <= hiscore_d;
  assign hiscore = hiscore_q;
`endif
  assign score     = score_q;
  assign level     = level_q;
  assign running   = running_q;
  assign game_over = game_over_q;
endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: directed stimulus against a cycle model of the game rules plus hand-computed checkpoints
module tb_score_counter;
  localparam int TD = 4, BP = 10, SMAX = 6399, STEP = 800;
  logic clk2 = 0, reset = 0, start = 0, collide = 0, bonus = 0, pause = 0;
  logic [12:0] score;
  logic [2:0] level;
  logic running, game_over;
`ifdef SCORE_HISCORE_EN
  logic [12:0] hiscore;
`endif
  int tests = 0, fails = 0;
  int m_score = 0, m_phase = 0, m_hi = 0;
  bit m_run = 0, m_over = 0;

  always #5 clk2 = ~clk2;

  score_counter #(.TICK_DIV(TD), .BONUS_PTS(BP), .SCORE_MAX(SMAX), .LEVEL_STEP(STEP)) dut (
    .clk2     (clk2),
    .reset    (reset),
    .start    (start),
    .collide  (collide),
    .bonus    (bonus),
    .pause    (pause),
    .score    (score),
    .level    (level),
    .running  (running),
`ifdef SCORE_HISCORE_EN
    .hiscore  (hiscore),
`endif
    .game_over(game_over)
  );

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Game rules: m_phase counts running, unpaused cycles; every TD-th one earns a point.
  always @(posedge clk2 or negedge reset)
    if (!reset) begin
      m_score <= 0; m_phase <= 0; m_hi <= 0; m_run <= 0; m_over <= 0;
    end else if (!m_run && start) begin
      m_run <= 1; m_over <= 0; m_score <= 0; m_phase <= 0;
    end else if (m_run && collide) begin
      m_run <= 0; m_over <= 1;
      if (m_score > m_hi) m_hi <= m_score;
    end else if (m_run && !pause) begin
      m_phase <= (m_phase + 1) % TD;
      m_score <= min_i(m_score + ((m_phase == TD - 1) ? 1 : 0) + (bonus ? BP : 0), SMAX);
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk2) begin
    check("model_score", 32'(score), m_score);
    check("model_level", 32'(level), min_i(m_score / STEP, 7));
    check("model_running", 32'(running), 32'(m_run));
    check("model_game_over", 32'(game_over), 32'(m_over));
`ifdef SCORE_HISCORE_EN
    check("model_hiscore", 32'(hiscore), m_hi);
`endif
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk2);
    #1;
  endtask

  initial begin
    cyc(3);
    check("rst_score", 32'(score), 0);
    check("rst_running", 32'(running), 0);
    reset = 1;
    collide = 1; cyc(2); collide = 0;
    check("idle_collide", 32'(game_over), 0);
    start = 1; cyc(1); start = 0;
    check("start_running", 32'(running), 1);
    check("start_score", 32'(score), 0);
    cyc(40);
    check("run40_score", 32'(score), 10);
    check("run40_level", 32'(level), 0);
    check("run40_running", 32'(running), 1);
    check("run40_over", 32'(game_over), 0);
    bonus = 1; cyc(1); bonus = 0;
    cyc(22);
    check("pre_combo", 32'(score), 25);
    bonus = 1; cyc(1); bonus = 0;
    check("tick_bonus_combo", 32'(score), 36);
    bonus = 1; cyc(620); bonus = 0;
    cyc(16);
    check("near_max", 32'(score), 6395);
    bonus = 1; cyc(1); bonus = 0;
    check("sat_bonus", 32'(score), 6399);
    check("sat_level", 32'(level), 7);
    start = 1; cyc(1); start = 0;
    cyc(20);
    check("sat_hold", 32'(score), 6399);
    check("start_in_run", 32'(running), 1);
    #2 reset = 0;
    #1;
    check("midrst_score", 32'(score), 0);
    check("midrst_level", 32'(level), 0);
    check("midrst_running", 32'(running), 0);
    @(posedge clk2); #1 reset = 1;
    // game 1: end at 123 with collide (and start) on a tick edge
    start = 1; cyc(1); start = 0;
    bonus = 1; cyc(11); bonus = 0;
    cyc(44);
    check("g1_pre", 32'(score), 123);
    collide = 1; start = 1; cyc(1); start = 0;
    check("collide_tick_score", 32'(score), 123);
    check("collide_over", 32'(game_over), 1);
    check("collide_running", 32'(running), 0);
    cyc(20); collide = 0;
    check("over_frozen", 32'(score), 123);
    start = 1; cyc(1); start = 0;
    check("restart_score", 32'(score), 0);
    check("restart_running", 32'(running), 1);
    // game 2: pause window at 50, end at 80
    bonus = 1; cyc(4); bonus = 0;
    cyc(36);
    check("pre_pause", 32'(score), 50);
    pause = 1; cyc(5);
    bonus = 1; cyc(1); bonus = 0;
    cyc(6); pause = 0;
    check("paused", 32'(score), 50);
    cyc(3);
    check("resume3", 32'(score), 50);
    cyc(1);
    check("resume4", 32'(score), 51);
    bonus = 1; cyc(2); bonus = 0;
    cyc(34);
    collide = 1; cyc(1); collide = 0;
    check("g2_end", 32'(score), 80);
`ifdef SCORE_HISCORE_EN
    check("hiscore_kept", 32'(hiscore), 123);
`endif
    // game 3: reset mid-game
    start = 1; cyc(1); start = 0;
    cyc(7);
    #2 reset = 0;
    #1;
    check("g3_rst_score", 32'(score), 0);
    check("g3_rst_running", 32'(running), 0);
    check("g3_rst_over", 32'(game_over), 0);
`ifdef SCORE_HISCORE_EN
    check("g3_rst_hiscore", 32'(hiscore), 0);
`endif
    @(posedge clk2); #1 reset = 1;
    cyc(2);
    check("idle_after_rst", 32'(running), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
